// File: rtl/stall_forward_ctrl.sv
// Hazard scoreboard for the 5-stage MIPS pipeline: tracks {rs, rt, wa, tnew} in E/M/W,
// raises the D-stage stall and selects operand forwarding for D and E.
module stall_forward_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [4:0]       wa_D,
   input  logic [1:0]       Tuse_rs,
   input  logic [1:0]       Tuse_rt,
   input  logic [1:0]       Tnew_D,
   output logic             stall,
   output logic [1:0]       fwd_rs_D,
   output logic [1:0]       fwd_rt_D,
   output logic [1:0]       fwd_rs_E,
   output logic [1:0]       fwd_rt_E,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wa;
      logic [1:0] tnew;
   } entry_t;

   entry_t ent_e, ent_m, ent_w;

   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // The nearest writer of r governs: an E match hides any older M match.
   function automatic logic op_hit(input logic [4:0] r, input logic [1:0] tuse,
                                   input entry_t e, input entry_t m);
      logic h;
      h = 1'b0;
      if (r != 5'd0) begin
         if (e.wa == r)      h = (e.tnew > tuse);
         else if (m.wa == r) h = (m.tnew > tuse);
      end
      return h;
   endfunction

   // newer_hit: a stage younger than M writes r, so neither M nor W may forward.
   function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic newer_hit,
                                          input entry_t m, input entry_t w);
      logic [1:0] s;
      s = 2'd0;
      if (r != 5'd0 && !newer_hit) begin
         if (m.wa == r)      s = (m.tnew == 2'd0) ? 2'd1 : 2'd0;
         else if (w.wa == r) s = 2'd2;
      end
      return s;
   endfunction

   always_comb begin
      stall    = op_hit(rs_D, Tuse_rs, ent_e, ent_m) | op_hit(rt_D, Tuse_rt, ent_e, ent_m);
      fwd_rs_D = fwd_sel(rs_D, (ent_e.wa == rs_D), ent_m, ent_w);
      fwd_rt_D = fwd_sel(rt_D, (ent_e.wa == rt_D), ent_m, ent_w);
      fwd_rs_E = fwd_sel(ent_e.rs, 1'b0, ent_m, ent_w);
      fwd_rt_E = fwd_sel(ent_e.rt, 1'b0, ent_m, ent_w);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_e     <= '0;
         ent_m     <= '0;
         ent_w     <= '0;
         stall_cnt <= '0;
      end else begin
         ent_w      <= ent_m;
         ent_w.tnew <= sat_dec(ent_m.tnew);
         ent_m      <= ent_e;
         ent_m.tnew <= sat_dec(ent_e.tnew);
         if (stall) ent_e <= '0;
         else       ent_e <= '{rs: rs_D, rt: rt_D, wa: wa_D, tnew: Tnew_D};
         if (stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_stall_forward_ctrl.sv
// Directed hazard scenarios followed by random instruction streams, checked against
// an issue-age model of in-flight instructions.
module tb_stall_forward_ctrl;

   localparam int CW      = 3;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    rs_D, rt_D, wa_D;
   logic [1:0]    Tuse_rs, Tuse_rt, Tnew_D;
   logic          stall;
   logic [1:0]    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
   logic [CW-1:0] stall_cnt;

   stall_forward_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .wa_D(wa_D),
      .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .Tnew_D(Tnew_D),
      .stall(stall),
      .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
      .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // In-flight instructions, index = stages past D (0 = E, 1 = M, 2 = W); tn is Tnew at issue.
   typedef struct {
      int rs;
      int rt;
      int wa;
      int tn;
   } ins_t;

   ins_t pipe[3];
   int   vectors     = 0;
   int   miscompares = 0;
   int   exp_cnt     = 0;

   function automatic int remaining(input int s);
      return (pipe[s].tn - s > 0) ? pipe[s].tn - s : 0;
   endfunction

   function automatic int nearest_writer(input int r, input int from);
      for (int s = from; s < 3; s++)
         if (r != 0 && pipe[s].wa == r) return s;
      return 3;
   endfunction

   function automatic int m_hit(input int r, input int tuse);
      int s;
      s = nearest_writer(r, 0);
      return (s <= 1 && remaining(s) > tuse) ? 1 : 0;
   endfunction

   function automatic int m_fwd(input int r, input int from);
      int s;
      s = nearest_writer(r, from);
      if (s == 1 && remaining(1) == 0) return 1;
      if (s == 2) return 2;
      return 0;
   endfunction

   function automatic int m_stall();
      return m_hit(int'(rs_D), int'(Tuse_rs)) | m_hit(int'(rt_D), int'(Tuse_rt));
   endfunction

   task automatic clear_model();
      for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
      exp_cnt = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".stall"},    32'(stall),     32'(m_stall()));
      check({tag, ".fwd_rs_D"}, 32'(fwd_rs_D),  32'(m_fwd(int'(rs_D), 0)));
      check({tag, ".fwd_rt_D"}, 32'(fwd_rt_D),  32'(m_fwd(int'(rt_D), 0)));
      check({tag, ".fwd_rs_E"}, 32'(fwd_rs_E),  32'(m_fwd(pipe[0].rs, 1)));
      check({tag, ".fwd_rt_E"}, 32'(fwd_rt_E),  32'(m_fwd(pipe[0].rt, 1)));
      check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
   endtask

   // Present one D instruction, check outputs at the falling edge, then advance one cycle.
   task automatic step(input string tag, input int rs, input int rt, input int wa,
                       input int tur, input int tut, input int tn, output int stalled);
      rs_D = 5'(rs); rt_D = 5'(rt); wa_D = 5'(wa);
      Tuse_rs = 2'(tur); Tuse_rt = 2'(tut); Tnew_D = 2'(tn);
      @(negedge clk);
      check_all(tag);
      stalled = m_stall();
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (stalled != 0) pipe[0] = '{0, 0, 0, 0};
      else              pipe[0] = '{rs, rt, wa, tn};
      if (stalled != 0 && exp_cnt < CNT_MAX) exp_cnt++;
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      clear_model();
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.cnt", 32'(stall_cnt), 32'd0);
      reset = 1'b0;
   endtask

   int st;
   int r_rs, r_rt, r_wa, r_tur, r_tut, r_tn;

   initial begin
      reset = 1'b1;
      rs_D = '0; rt_D = '0; wa_D = '0;
      Tuse_rs = 2'd3; Tuse_rt = 2'd3; Tnew_D = 2'd0;
      clear_model();
      #12 reset = 1'b0;
      step("after_reset", 0, 0, 0, 3, 3, 0, st);

      // lw $5 then beq $5: two stall cycles, then MEM/WB forward
      pulse_reset();
      step("lw", 0, 0, 5, 3, 3, 2, st);
      step("beq1", 5, 0, 0, 0, 3, 0, st);
      step("beq2", 5, 0, 0, 0, 3, 0, st);
      #1;
      check("lw.stall_end", 32'(stall), 32'd0);
      check("lw.fwd_rs_D", 32'(fwd_rs_D), 32'd2);
      check("lw.cnt", 32'(stall_cnt), 32'd2);
      step("beq3", 5, 0, 0, 0, 3, 0, st);

      // addu $3 then addu using $3 in E
      step("addu_p", 0, 0, 3, 3, 3, 1, st);
      step("addu_c", 3, 0, 6, 1, 3, 1, st);
      check("addu.fwd_rs_E", 32'(fwd_rs_E), 32'd1);
      step("addu_n1", 0, 0, 0, 3, 3, 0, st);
      step("addu_n2", 0, 0, 0, 3, 3, 0, st);

      // addu $3 then jr $3
      step("jr_p", 0, 0, 3, 3, 3, 1, st);
      step("jr1", 3, 0, 0, 0, 3, 0, st);
      #1;
      check("jr.fwd_rs_D", 32'(fwd_rs_D), 32'd1);
      step("jr2", 3, 0, 0, 0, 3, 0, st);

      // wa=0 producer, r=0 consumer
      step("z_p", 0, 0, 0, 3, 3, 2, st);
      step("z_c", 0, 0, 0, 0, 0, 0, st);
      step("z_n", 0, 0, 0, 3, 3, 0, st);

      // two writers of $4 then sw rt=$4: younger one wins
      step("sw_p1", 0, 0, 4, 3, 3, 1, st);
      step("sw_p2", 0, 0, 4, 3, 3, 1, st);
      step("sw_c", 0, 4, 0, 3, 2, 0, st);
      check("sw.fwd_rt_E", 32'(fwd_rt_E), 32'd1);

      // rs==rt on a load result: one stall per cycle
      step("dup_p", 0, 0, 7, 3, 3, 2, st);
      step("dup1", 7, 7, 0, 0, 0, 0, st);
      step("dup2", 7, 7, 0, 0, 0, 0, st);
      step("dup3", 7, 7, 0, 0, 0, 0, st);

      // reset mid-stream with E={wa=5,tnew=2}
      step("mr_lw", 0, 0, 5, 3, 3, 2, st);
      rs_D = 5'd5; Tuse_rs = 2'd0; rt_D = 5'd0; Tuse_rt = 2'd3; Tnew_D = 2'd0; wa_D = 5'd0;
      #1;
      check("mr.pre_stall", 32'(stall), 32'd1);
      reset = 1'b1;
      #1;
      check("mr.stall", 32'(stall), 32'd0);
      check("mr.fwd", 32'({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}), 32'd0);
      check("mr.cnt", 32'(stall_cnt), 32'd0);
      clear_model();
      reset = 1'b0;
      step("mr_after", 5, 0, 0, 0, 3, 0, st);

      // random stream; stalled D inputs are held, as upstream would
      st = 0;
      for (int i = 0; i < 400; i++) begin
         if (st == 0) begin
            r_rs  = $urandom_range(0, 7);
            r_rt  = $urandom_range(0, 7);
            r_wa  = $urandom_range(0, 7);
            r_tur = $urandom_range(0, 3);
            r_tut = $urandom_range(0, 3);
            r_tn  = $urandom_range(0, 2);
         end
         step("rand", r_rs, r_rt, r_wa, r_tur, r_tut, r_tn, st);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
